// File: rtl/icache_rom_responder_if.sv
// Request/response bus between an instruction fetch requester and the
// ROM responder. Requests carry a word address and an opaque tag. Each
// response returns the fetched word with that same tag.
interface icache_rom_responder_if #(
   parameter int TAG_WIDTH = 16
);
   // Request channel
   logic                 req_valid;
   logic [29:0]          req_addr;
   logic [TAG_WIDTH-1:0] req_tag;
   logic                 req_ready;

   // Response channel
   logic                 rsp_valid;
   logic [31:0]          rsp_data;
   logic [TAG_WIDTH-1:0] rsp_tag;
   logic                 rsp_ready;

   // Fetch side: issues requests and consumes responses
   modport master (
      output req_valid, req_addr, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_tag
   );

   // Memory side: accepts requests and produces responses
   modport slave (
      input  req_valid, req_addr, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_tag
   );
endinterface

// File: rtl/icache_rom_responder.sv
// Instruction-memory responder for the icache request/response protocol.
// Each accepted request reads the local word memory. The word and its tag
// pass through a fixed-latency pipeline and land in an in-order response
// queue. A credit counter limits outstanding requests to the queue depth,
// so the pipeline never has to stall. Response back-pressure cannot drop
// or reorder data.
module icache_rom_responder #(
   parameter int TAG_WIDTH     = 16,
   parameter int MEM_ADDR_BITS = 10,
   parameter int LATENCY       = 2,   // legal range 1..4
   parameter int RSP_DEPTH     = 4    // must be >= LATENCY
) (
   input  logic                     clk,
   input  logic                     reset,
   icache_rom_responder_if.slave    bus,
   input  logic                     wr_en,
   input  logic [MEM_ADDR_BITS-1:0] wr_addr,
   input  logic [31:0]              wr_data
);

   localparam int CW        = $clog2(RSP_DEPTH + 1);
   localparam int PW        = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int MEM_WORDS = 1 << MEM_ADDR_BITS;
   localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

   // ------------------------------------------------------------------
   // Handshakes and credits
   // ------------------------------------------------------------------
   logic          req_fire;
   logic          rsp_fire;
   logic [CW-1:0] credits;
   logic [CW-1:0] credits_next;

   // req_ready depends only on the credit register, never on req_valid.
   assign bus.req_ready = (credits < DEPTH_C);
   assign req_fire      = bus.req_valid && bus.req_ready;
   assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;

   // Next credit count: +1 on a request alone, -1 on a response alone.
   always_comb begin
      // NOTE: default assignment first so every path drives credits_next; no latch.
      credits_next = credits;
      unique case ({req_fire, rsp_fire})
         2'b10:   credits_next = credits + 1'b1;
         2'b01:   credits_next = credits - 1'b1;
         default: credits_next = credits;
      endcase
   end

   // Credit register
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      if (reset) credits <= '0;
      else       credits <= credits_next;
   end

   // ------------------------------------------------------------------
   // Instruction memory
   // ------------------------------------------------------------------
   logic [31:0]              mem [MEM_WORDS];
   logic [MEM_ADDR_BITS-1:0] rd_addr;
   logic                     unused_addr_hi;

   // Addresses wrap modulo the memory depth. The upper bits are not used.
   assign rd_addr        = bus.req_addr[MEM_ADDR_BITS-1:0];
   assign unused_addr_hi = ^bus.req_addr[29:MEM_ADDR_BITS];

   // Boot-time load port. A read in the same cycle sees the old word.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays have no reset; contents survive reset and come only from wr_en.
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // ------------------------------------------------------------------
   // Read pipeline
   // ------------------------------------------------------------------
   // Stage "in" is the read in the accepting cycle T. LATENCY-1 register
   // stages follow it. The last one pushes into the queue at the end of
   // cycle T+LATENCY-1.
   logic                 in_valid;
   logic [31:0]          in_data;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 push_valid;
   logic [31:0]          push_data;
   logic [TAG_WIDTH-1:0] push_tag;

   assign in_valid = req_fire;
   assign in_data  = mem[rd_addr];
   assign in_tag   = bus.req_tag;

   generate
      if (LATENCY > 1) begin : g_pipe
         localparam int NSTG = LATENCY - 1;
         logic                 st_valid [NSTG];
         logic [31:0]          st_data  [NSTG];
         logic [TAG_WIDTH-1:0] st_tag   [NSTG];

         // Valid bits advance every cycle. The pipeline never stalls.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < NSTG; k++) st_valid[k] <= 1'b0;
            end else begin
               st_valid[0] <= in_valid;
               for (int k = 1; k < NSTG; k++) st_valid[k] <= st_valid[k-1];
            end
         end

         // Data and tag ride alongside the valid bits. Valid alone qualifies them.
         always_ff @(posedge clk) begin
            st_data[0] <= in_data;
            st_tag[0]  <= in_tag;
            for (int k = 1; k < NSTG; k++) begin
               st_data[k] <= st_data[k-1];
               st_tag[k]  <= st_tag[k-1];
            end
         end

         assign push_valid = st_valid[NSTG-1];
         assign push_data  = st_data[NSTG-1];
         assign push_tag   = st_tag[NSTG-1];
      end else begin : g_nopipe
         assign push_valid = in_valid;
         assign push_data  = in_data;
         assign push_tag   = in_tag;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Response queue
   // ------------------------------------------------------------------
   logic [31:0]          q_data [RSP_DEPTH];
   logic [TAG_WIDTH-1:0] q_tag  [RSP_DEPTH];
   logic [PW-1:0]        q_head;
   logic [PW-1:0]        q_tail;
   logic [CW-1:0]        q_count;
   logic                 q_empty;
   logic                 q_full;

   assign q_empty = (q_count == '0);
   assign q_full  = (q_count == DEPTH_C);

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   // Queue storage. Written at the tail on every pipeline push.
   always_ff @(posedge clk) begin
      if (push_valid) begin
         q_data[q_tail] <= push_data;
         q_tag[q_tail]  <= push_tag;
      end
   end

   // Queue pointers and occupancy. A push and a pop in one cycle cancel out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_head  <= '0;
         q_tail  <= '0;
         q_count <= '0;
      end else begin
         if (push_valid) q_tail <= next_ptr(q_tail);
         if (rsp_fire)   q_head <= next_ptr(q_head);
         if (push_valid && !rsp_fire)      q_count <= q_count + 1'b1;
         else if (!push_valid && rsp_fire) q_count <= q_count - 1'b1;
      end
   end

   // The head entry drives the response port. Outputs read zero while empty.
   assign bus.rsp_valid = !q_empty;
   assign bus.rsp_data  = q_empty ? '0 : q_data[q_head];
   assign bus.rsp_tag   = q_empty ? '0 : q_tag[q_head];

   // ------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push_valid && q_full && !rsp_fire));

   a_credit_bound : assert property (@(posedge clk) disable iff (reset)
      credits <= DEPTH_C);

endmodule

// File: doc/icache_rom_responder.md
Name: icache_rom_responder

Overview:
- Responder end of the instruction-cache request/response protocol.
- Accepts word-addressed fetch requests carrying an opaque tag. Each request reads a local instruction memory, and the block returns the 32-bit word with the same tag, in request order.
- Sits where the core's icache or memory side would be, and is used as the fetch-stage backing store in small configurations and benches.
- Flow control is credit-based, so back-pressure on the response side never drops or reorders data.

Parameters:
- TAG_WIDTH, 16, width of the request/response tag (warp id plus uuid bits); passed through unmodified.
- MEM_ADDR_BITS, 10, log2 of memory depth in 32-bit words. Request address is used modulo 2^MEM_ADDR_BITS.
- LATENCY, 2, read pipeline depth in cycles (legal range 1..4).
- RSP_DEPTH, 4, maximum outstanding requests (pipeline plus response queue). Must be >= LATENCY.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_addr  in  30  word address (PC[31:2])
- req_tag  in  TAG_WIDTH  request tag
- req_ready  out  1  request can be accepted this cycle
- rsp_valid  out  1  response valid
- rsp_data  out  32  instruction word
- rsp_tag  out  TAG_WIDTH  tag of the originating request
- rsp_ready  in  1  consumer accepts response
- wr_en  in  1  memory load strobe (boot/init)
- wr_addr  in  MEM_ADDR_BITS  load word address
- wr_data  in  32  load data

Behaviour:
- Reset (async assert, sync release):
  - Credit counter = 0, all pipeline valid bits = 0, response queue empty.
  - Outputs: rsp_valid = 0, rsp_data = 0, rsp_tag = 0, req_ready = 1.
  - Memory contents are not reset.
  - Reset mid-operation discards all in-flight and queued responses; no response for them is ever produced.
- Request handshake:
  - Fire = req_valid && req_ready.
  - req_ready = (credits < RSP_DEPTH). It is registered-state derived and never depends combinationally on req_valid.
- Response handshake:
  - Fire = rsp_valid && rsp_ready.
  - rsp_valid/rsp_data/rsp_tag hold stable while rsp_valid && !rsp_ready.
- Credit counter, width $clog2(RSP_DEPTH+1):
  - +1 on request fire only; -1 on response fire only.
  - Unchanged when both fire in the same cycle.
  - Never exceeds RSP_DEPTH and never underflows.
- Read pipeline:
  - On request fire in cycle T, memory is read at req_addr[MEM_ADDR_BITS-1:0].
  - Tag and valid travel alongside the data through LATENCY stages.
  - The stage output is pushed into the response queue at the end of cycle T+LATENCY-1.
- Response queue:
  - Depth RSP_DEPTH; head drives the rsp_* outputs.
  - Earliest rsp_valid is cycle T+LATENCY (LATENCY=1: the cycle after acceptance).
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Overflow is impossible by construction of the credits. An assertion fires if a push occurs when full.
- Ordering: responses are strictly in acceptance order. Tag is returned bit-exact.
- Memory write:
  - wr_en writes wr_data at wr_addr at the clock edge.
  - Same-cycle read and write to the same address returns OLD data (read-first).
  - A write affects only requests accepted in later cycles.
- Pipeline never stalls. Back-pressure is absorbed solely by the queue plus credits. Throughput is one request per cycle while rsp_ready is held high.
- Upper address bits above MEM_ADDR_BITS are ignored (wrap-around). No error response exists.

Test Plan:
1. Load memory via wr_en with word i = 32'h1000_0000 + i for i = 0..15. Issue a single request addr=5, tag=16'h0A03, rsp_ready=1 -> rsp_valid exactly 2 cycles after fire with data 32'h1000_0005, tag 16'h0A03.
2. Back-to-back requests addr 0..7 with rsp_ready=1 -> 8 responses on 8 consecutive cycles, in order, data 0x1000_0000..0x1000_0007; req_ready stays 1.
3. Hold rsp_ready=0 and keep req_valid=1 -> exactly 4 requests accepted, req_ready=0 thereafter, rsp_valid=1 with the first response stable. Raise rsp_ready -> 4 in-order responses; req_ready returns to 1 the cycle after the first response fire.
4. Write wr_addr=3, wr_data=32'hDEAD_BEEF in the same cycle as a request addr=3 -> that response returns 32'h1000_0003. A request the next cycle -> 32'hDEAD_BEEF.
5. Request addr=30'h0000_0405 (above the 1024-word range) -> returns contents of word 5.
6. Assert reset while 3 requests are outstanding -> rsp_valid=0 and req_ready=1 immediately (async). After release, no stale responses appear, and a new request addr=1 returns 32'h1000_0001.
